// File: rtl/divider_32.sv
// Multi-cycle restoring shift-subtract divider with start/busy/done handshake.
// Define SIGNED_DIV_EN for two's-complement operands (default: unsigned).
module divider_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r, q, b;
  logic             dz, neg_q, neg_r;
  logic             accept, last;
  logic [WIDTH:0]   rs, diff;
  logic [WIDTH-1:0] r_nx, q_nx, quo_fix, rem_fix;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             a_neg, b_neg;

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));
  assign busy   = (state == RUN);
  assign done   = (state == FIN);

  always_comb begin
`ifdef SIGNED_DIV_EN
    a_neg = A[WIDTH-1];
    b_neg = B[WIDTH-1];
    a_mag = a_neg ? -A : A;
    b_mag = b_neg ? -B : B;
`else
    a_neg = 1'b0;
    b_neg = 1'b0;
    a_mag = A;
    b_mag = B;
`endif
  end

  // One restoring step; the extra bit keeps large divisors from overflowing.
  always_comb begin
    rs   = {r, q[WIDTH-1]};
    diff = rs - {1'b0, b};
    if (!diff[WIDTH]) begin
      r_nx = diff[WIDTH-1:0];
      q_nx = {q[WIDTH-2:0], 1'b1};
    end else begin
      r_nx = rs[WIDTH-1:0];
      q_nx = {q[WIDTH-2:0], 1'b0};
    end
    quo_fix = neg_q ? -q_nx : q_nx;
    rem_fix = neg_r ? -r_nx : r_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = IDLE;
    unique case (state)
      IDLE:    state_nx = accept ? RUN : IDLE;
      RUN:     state_nx = last ? FIN : RUN;
      FIN:     state_nx = accept ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A zero divisor spends one RUN cycle holding A in q, then finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      r        <= '0;
      q        <= '0;
      b        <= '0;
      dz       <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
    end else if (accept) begin
      r <= '0;
      b <= b_mag;
      if (B == '0) begin
        dz    <= 1'b1;
        q     <= A;
        cnt   <= CW'(WIDTH - 1);
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end else begin
        dz    <= 1'b0;
        q     <= a_mag;
        cnt   <= '0;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
      end
    end else if (state == RUN) begin
      if (last) begin
        if (dz) begin
          quo      <= '1;
          rem      <= q;
          div_zero <= 1'b1;
        end else begin
          quo      <= quo_fix;
          rem      <= rem_fix;
          div_zero <= 1'b0;
        end
      end else begin
        r   <= r_nx;
        q   <= q_nx;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_divider_32.sv
// Self-checking bench for divider_32: vector table plus handshake,
// ignored-start and mid-operation reset sequences.
module tb_divider_32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] A, B;
  logic        busy, done, div_zero;
  logic [31:0] quo, rem;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  divider_32 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .quo(quo), .rem(rem),
    .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    A = a;
    B = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen; ends at a negedge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) break;
    end
    if (!done) begin
      fails++;
      tests++;
      $display("FAIL timeout: got no done after %0d edges, expected done", lat);
    end
  endtask

  initial begin
    int lat;
    int ndone;
    int first;

    vecs.push_back('{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32});
    vecs.push_back('{32'd10, 32'd3, 32'd3, 32'd1, 1'b0, 32});
    vecs.push_back('{32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1});
    vecs.push_back('{32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 32});
    vecs.push_back('{32'd7, 32'd7, 32'd1, 32'd0, 1'b0, 32});
    vecs.push_back('{32'd6, 32'd7, 32'd0, 32'd6, 1'b0, 32});
    vecs.push_back('{32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 32'd0, 1'b0, 32});
    vecs.push_back('{32'h80000000, 32'h80000000, 32'd1, 32'd0, 1'b0, 32});
    vecs.push_back('{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 32});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 32});
    vecs.push_back('{32'd1000000, 32'd1000, 32'd1000, 32'd0, 1'b0, 32});
    vecs.push_back('{32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1});
`ifdef SIGNED_DIV_EN
    vecs.push_back('{32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 32});
    vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 32});
    vecs.push_back('{32'hFFFFFFFF, 32'h80000000, 32'd0, 32'hFFFFFFFF, 1'b0, 32});
    vecs.push_back('{32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 32});
`else
    vecs.push_back('{32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1'b0, 32});
    vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 32});
    vecs.push_back('{32'hFFFFFFFF, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0, 32});
    vecs.push_back('{32'd7, 32'hFFFFFFFE, 32'd0, 32'd7, 1'b0, 32});
`endif

    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_quo", quo, 32'd0);
    chk("reset_rem", rem, 32'd0);
    chk("reset_flags", {29'd0, busy, done, div_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Each vector is issued in the FIN cycle of the previous one.
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_busy_run", i), {31'd0, busy}, 32'd1);
      wait_done(lat);
      chk($sformatf("v%0d_quo", i), quo, vecs[i].q);
      chk($sformatf("v%0d_rem", i), rem, vecs[i].r);
      chk($sformatf("v%0d_dz", i), {31'd0, div_zero}, {31'd0, vecs[i].dz});
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_busy_fin", i), {31'd0, busy}, 32'd0);
    end

    // Outputs hold after done, and done is a single-cycle pulse.
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    chk("hold_quo", quo, vecs[vecs.size()-1].q);
    chk("hold_rem", rem, vecs[vecs.size()-1].r);

    // A second start while busy is ignored; operand changes have no effect.
    issue(32'hFFFFFFFF, 32'd1);
    ndone = 0;
    first = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 4) begin
        start = 1'b1;
        A = 32'd9;
        B = 32'd9;
      end
      if (c == 5) begin
        start = 1'b0;
        A = 32'd123;
        B = 32'd45;
      end
      if (done) begin
        ndone++;
        if (first == 0) first = c;
      end
    end
    chk("ign_ndone", 32'(ndone), 32'd1);
    chk("ign_lat", 32'(first), 32'd32);
    chk("ign_quo", quo, 32'hFFFFFFFF);
    chk("ign_rem", rem, 32'd0);

    // Reset in the middle of an operation abandons it.
    issue(32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_quo", quo, 32'd0);
    chk("mid_rst_rem", rem, 32'd0);
    chk("mid_rst_flags", {29'd0, busy, done, div_zero}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      if (done) ndone++;
    end
    chk("mid_rst_nodone", 32'(ndone), 32'd0);
    issue(32'd20, 32'd6);
    wait_done(lat);
    chk("post_rst_quo", quo, 32'd3);
    chk("post_rst_rem", rem, 32'd2);
    chk("post_rst_lat", 32'(lat), 32'd32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
